output_weight_updater: RTL

Sequential backprop update engine for the 8 hidden-to-output weights of the idann network. It sits between the backprop error path and `output_neuron`. It holds the weight registers and drives the packed weight bus that `output_neuron` consumes. When the state machine's backward pass starts, it updates all 8 weights serially, one per cycle, then signals completion back to the state machine as the `b_end` condition.

---
 rtl/idann_pkg.sv | 23 ++
 rtl/weight_sat_update.sv | 39 +++
 rtl/output_weight_updater.sv | 105 ++++++++++
 3 files changed

// File: rtl/idann_pkg.sv
// Shared constants, FSM state type and default-weight helper for the idann
// weight-update engines.
package idann_pkg;

    localparam int N_WEIGHTS = 8;
    localparam int W_WIDTH   = 8;
    localparam int HV_WIDTH  = 10;
    localparam int ERR_WIDTH = 12;
    localparam int LR_SHIFT  = 6;
    localparam int IDX_WIDTH = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        UPDATE = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Power-up / init weight for slot k is simply k+1.
    function automatic logic [W_WIDTH-1:0] default_weight(input int k);
        return W_WIDTH'(k + 1);
    endfunction

endpackage

// File: rtl/weight_sat_update.sv
// Single-weight gradient step: w - ((err * h) >>> LR_SHIFT), saturated to the
// signed weight range. Purely combinational so the hidden-layer updater can reuse it.
module weight_sat_update
    import idann_pkg::*;
(
    input  logic [W_WIDTH-1:0]   w,
    input  logic [ERR_WIDTH-1:0] err,
    input  logic [HV_WIDTH-1:0]  h,
    output logic [W_WIDTH-1:0]   w_new,
    output logic                 sat
);

    localparam int P_WIDTH = ERR_WIDTH + HV_WIDTH + 1;
    localparam int N_WIDTH = P_WIDTH + 1;

    localparam logic signed [N_WIDTH-1:0] W_MAX = N_WIDTH'((1 << (W_WIDTH - 1)) - 1);
    localparam logic signed [N_WIDTH-1:0] W_MIN = -N_WIDTH'(1 << (W_WIDTH - 1));

    logic signed [P_WIDTH-1:0] p;
    logic signed [P_WIDTH-1:0] d;
    logic signed [N_WIDTH-1:0] n;

    always_comb begin
        // h is unsigned, so a zero sign bit keeps it non-negative in the signed product.
        p = $signed(err) * $signed({1'b0, h});
        d = p >>> LR_SHIFT;
        n = $signed({{(N_WIDTH-W_WIDTH){w[W_WIDTH-1]}}, w}) - $signed({d[P_WIDTH-1], d});
        sat   = 1'b0;
        w_new = n[W_WIDTH-1:0];
        if (n > W_MAX) begin
            w_new = W_MAX[W_WIDTH-1:0];
            sat   = 1'b1;
        end else if (n < W_MIN) begin
            w_new = W_MIN[W_WIDTH-1:0];
            sat   = 1'b1;
        end
    end

endmodule

// File: rtl/output_weight_updater.sv
// Serial backprop updater for the hidden-to-output weights: one weight per cycle
// from a snapshot of err/h, then a one-cycle done pulse.
module output_weight_updater
    import idann_pkg::*;
(
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          init_i,
    input  logic                          start_i,
    input  logic [ERR_WIDTH-1:0]          err_i,
    input  logic [N_WEIGHTS*HV_WIDTH-1:0] h_i,
    output logic [N_WEIGHTS*W_WIDTH-1:0]  weights_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic                          sat_o,
    output logic [1:0]                    state_o
);

    // Handshake: start_i is a request accepted only on an edge where the engine
    // is IDLE (busy_o low); it is dropped, not queued, while busy_o is high.
    // done_o pulses for exactly one cycle when a pass finishes normally.

    state_t                        state;
    logic [IDX_WIDTH-1:0]          idx;
    logic [W_WIDTH-1:0]            w_q [N_WEIGHTS];
    logic [ERR_WIDTH-1:0]          err_q;
    logic [N_WEIGHTS*HV_WIDTH-1:0] h_q;

    logic [HV_WIDTH-1:0] h_sel;
    logic [W_WIDTH-1:0]  w_sel;
    logic [W_WIDTH-1:0]  w_next;
    logic                sat_next;

    always_comb begin
        h_sel = h_q[idx*HV_WIDTH +: HV_WIDTH];
        w_sel = w_q[idx];
    end

    weight_sat_update u_weight_sat_update (
        .w     (w_sel),
        .err   (err_q),
        .h     (h_sel),
        .w_new (w_next),
        .sat   (sat_next)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state  <= IDLE;
            idx    <= '0;
            err_q  <= '0;
            h_q    <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            sat_o  <= 1'b0;
            for (int k = 0; k < N_WEIGHTS; k++) w_q[k] <= default_weight(k);
        end else begin
            done_o <= 1'b0;
            if (init_i) begin
                // Abort wins over everything, including a pass about to complete.
                state  <= IDLE;
                idx    <= '0;
                busy_o <= 1'b0;
                sat_o  <= 1'b0;
                for (int k = 0; k < N_WEIGHTS; k++) w_q[k] <= default_weight(k);
            end else begin
                case (state)
                    IDLE: begin
                        if (start_i) begin
                            err_q  <= err_i;
                            h_q    <= h_i;
                            idx    <= '0;
                            state  <= UPDATE;
                            busy_o <= 1'b1;
                        end
                    end
                    UPDATE: begin
                        w_q[idx] <= w_next;
                        if (sat_next) sat_o <= 1'b1;
                        idx <= idx + 1'b1;
                        if (idx == IDX_WIDTH'(N_WEIGHTS - 1)) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        weights_o = '0;
        for (int k = 0; k < N_WEIGHTS; k++) weights_o[k*W_WIDTH +: W_WIDTH] = w_q[k];
        state_o = state;
    end

endmodule
